// File: rtl/floating_point_normalize_pkg.sv
// Shared floating-point constants: GRS bit positions, rounding-mode codes
// and the mantissa width legality check used by the normalizer and rounder.
package floating_point_normalize_pkg;

    localparam int grs_g = 2;
    localparam int grs_r = 1;
    localparam int grs_s = 0;

    typedef enum logic [2:0] {
        rm_rne = 3'd0,
        rm_rtz = 3'd1,
        rm_rdn = 3'd2,
        rm_rup = 3'd3,
        rm_rmm = 3'd4
    } round_mode_t;

    // Raw mantissa needs 2 integer bits, the fraction and G/R/S room.
    function automatic bit mant_width_ok(int mant_width, int frac_width);
        return mant_width >= frac_width + 5;
    endfunction

endpackage

// File: rtl/floating_point_normalize_if.sv
// Operand/result handshake bundle between the FPU datapath, the normalizer
// and the rounding stage.
interface floating_point_normalize_if #(
    parameter int frac_width = 23,
    parameter int exp_width  = 8,
    parameter int mant_width = 28
);
    logic                        in_valid;
    logic                        in_ready;
    logic                        in_sign;
    logic signed [exp_width+1:0] in_exp;
    logic [mant_width-1:0]       in_mant;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_sign;
    logic [exp_width-1:0]        out_exp;
    logic [frac_width+2:0]       out_frac;
    logic                        out_zero;
    logic                        out_overflow;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_frac, out_zero, out_overflow
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_frac, out_zero, out_overflow
    );
endinterface

// File: rtl/floating_point_sticky_shift.sv
// One-bit mantissa shift step with exponent adjust and sticky collection.
// Right shifts fold the dropped LSB into sticky; left shifts never lose bits.
module floating_point_sticky_shift #(
    parameter int mant_width = 28,
    parameter int ew2        = 10
) (
    input  logic [mant_width-1:0] m,
    input  logic signed [ew2-1:0] e,
    input  logic                  sticky,
    input  logic                  right,
    output logic [mant_width-1:0] m_nxt,
    output logic signed [ew2-1:0] e_nxt,
    output logic                  sticky_nxt
);
    localparam logic signed [ew2-1:0] e_one = ew2'(1);

    always_comb begin
        m_nxt      = m;
        e_nxt      = e;
        sticky_nxt = sticky;
        if (right) begin
            m_nxt      = m >> 1;
            e_nxt      = e + e_one;
            sticky_nxt = sticky | m[0];
        end else begin
            m_nxt = m << 1;
            e_nxt = e - e_one;
        end
    end
endmodule

// File: rtl/floating_point_normalize.sv
// Iterative normalizer: one shift per cycle until the hidden bit lands at
// mant_width-2, with gradual underflow, zero and overflow detection.
module floating_point_normalize
    import floating_point_normalize_pkg::*;
#(
    parameter int frac_width = 23,
    parameter int exp_width  = 8,
    parameter int mant_width = 28
) (
    input logic                     clk,
    input logic                     reset,
    floating_point_normalize_if.slave bus
);
    localparam int ew2 = exp_width + 2;
    localparam logic signed [ew2-1:0] e_collapse = ew2'(-(frac_width + 3));
    localparam logic signed [ew2-1:0] e_one      = ew2'(1);
    localparam logic signed [ew2-1:0] e_ovf      = ew2'((1 << exp_width) - 1);

    if (!mant_width_ok(mant_width, frac_width)) begin : g_width_chk
        $error("mant_width must be at least frac_width+5");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;
    state_t state, state_nxt;

    logic [mant_width-1:0] m, m_sh;
    logic signed [ew2-1:0] e, e_sh;
    logic                  sticky, sticky_sh, sign;
    logic                  do_capture, act_right, act_left, act_collapse, act_finish;

    floating_point_sticky_shift #(.mant_width(mant_width), .ew2(ew2)) u_shift (
        .m(m), .e(e), .sticky(sticky), .right(act_right),
        .m_nxt(m_sh), .e_nxt(e_sh), .sticky_nxt(sticky_sh)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        do_capture   = 1'b0;
        act_right    = 1'b0;
        act_left     = 1'b0;
        act_collapse = 1'b0;
        act_finish   = 1'b0;
        case (state)
            IDLE: if (bus.in_valid) begin
                do_capture = 1'b1;
                state_nxt  = (bus.in_mant == '0) ? OUT : SHIFT;
            end
            SHIFT: begin
                if (m[mant_width-1])                    act_right = 1'b1;
                else if (e <= e_collapse)               act_collapse = 1'b1;
                else if (e < e_one)                     act_right = 1'b1;
                else if (!m[mant_width-2] && e > e_one) act_left = 1'b1;
                else                                    act_finish = 1'b1;
                if (act_collapse || act_finish) state_nxt = OUT;
            end
            OUT: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m                <= '0;
            e                <= '0;
            sticky           <= 1'b0;
            sign             <= 1'b0;
            bus.out_exp      <= '0;
            bus.out_frac     <= '0;
            bus.out_zero     <= 1'b0;
            bus.out_overflow <= 1'b0;
        end else begin
            if (do_capture) begin
                m      <= bus.in_mant;
                e      <= bus.in_exp;
                sticky <= 1'b0;
                sign   <= bus.in_sign;
                if (bus.in_mant == '0) begin
                    bus.out_exp      <= '0;
                    bus.out_frac     <= '0;
                    bus.out_zero     <= 1'b1;
                    bus.out_overflow <= 1'b0;
                end
            end
            if (act_right || act_left) begin
                m      <= m_sh;
                e      <= e_sh;
                sticky <= sticky_sh;
            end
            // Far below the subnormal range only the sticky bit survives.
            if (act_collapse) begin
                bus.out_exp         <= '0;
                bus.out_frac        <= '0;
                bus.out_frac[grs_s] <= 1'b1;
                bus.out_zero        <= 1'b0;
                bus.out_overflow    <= 1'b0;
            end
            if (act_finish) begin
                bus.out_zero <= 1'b0;
                if (e >= e_ovf) begin
                    bus.out_overflow <= 1'b1;
                    bus.out_exp      <= '1;
                    bus.out_frac     <= '0;
                end else begin
                    bus.out_overflow <= 1'b0;
                    bus.out_exp      <= m[mant_width-2] ? e[exp_width-1:0] : '0;
                    bus.out_frac     <= {m[mant_width-3 -: frac_width+2],
                                         sticky | (|m[mant_width-frac_width-5:0])};
                end
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == OUT);
    assign bus.out_sign  = sign;
endmodule
